// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: FSM state encodings
// and the default multdiv timeout.
package pipe_ctrl_pkg;

    // Encoding 2'b10 is held back for a future MD_DONE state.
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_MD_WAIT = 2'b01;

    localparam int MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// stall-cycle performance counter.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline latch-enable / flush controller with multdiv go/wait/timeout
// sequencing and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 16,
    parameter int TO_W       = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             la_stall,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             mw_we,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_go,
    output logic             md_timeout,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        pc_we      = 1'b1;
        fd_we      = 1'b1;
        dx_we      = 1'b1;
        xm_we      = 1'b1;
        mw_we      = 1'b1;
        fd_flush   = 1'b0;
        dx_bubble  = 1'b0;
        xm_bubble  = 1'b0;
        md_go      = 1'b0;
        md_timeout = 1'b0;
        md_busy    = 1'b0;

        if (!reset) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_we     = 1'b0;
            mw_we     = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            xm_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_MD_WAIT: begin
                    md_busy = 1'b1;
                    if (md_ready) begin
                        state_d = ST_RUN;
                    end else if (to_cnt_q == TO_LAST) begin
                        md_timeout = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        // Hold F/D/X; XM takes bubbles while MW drains.
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_we     = 1'b0;
                        xm_bubble = 1'b1;
                        to_cnt_d  = to_cnt_q + TO_W'(1);
                    end
                end
                default: begin
                    // Unused encodings fall back to RUN behaviour.
                    if (md_start) begin
                        md_go     = 1'b1;
                        state_d   = ST_MD_WAIT;
                        to_cnt_d  = '0;
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_we     = 1'b0;
                        xm_bubble = 1'b1;
                    end else if (branch_taken) begin
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (la_stall) begin
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (~pc_we),
        .count_o (stall_count)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a default instance plus a 4-bit
// counter instance, both fed the same stimulus.
module tb_pipe_stall_ctrl;

    localparam int MD_TO = 40;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, la_stall, branch_taken, md_start, md_ready;

    logic pc_we, fd_we, dx_we, xm_we, mw_we;
    logic fd_flush, dx_bubble, xm_bubble, md_go, md_timeout, md_busy;
    logic [15:0] stall_count;

    logic s_pc_we, s_fd_we, s_dx_we, s_xm_we, s_mw_we;
    logic s_fd_flush, s_dx_bubble, s_xm_bubble, s_md_go, s_md_timeout, s_md_busy;
    logic [3:0] s_stall_count;

    pipe_stall_ctrl dut (
        .clock(clock), .reset(reset), .la_stall(la_stall),
        .branch_taken(branch_taken), .md_start(md_start), .md_ready(md_ready),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
        .md_go(md_go), .md_timeout(md_timeout), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .la_stall(la_stall),
        .branch_taken(branch_taken), .md_start(md_start), .md_ready(md_ready),
        .pc_we(s_pc_we), .fd_we(s_fd_we), .dx_we(s_dx_we), .xm_we(s_xm_we),
        .mw_we(s_mw_we), .fd_flush(s_fd_flush), .dx_bubble(s_dx_bubble),
        .xm_bubble(s_xm_bubble), .md_go(s_md_go), .md_timeout(s_md_timeout),
        .md_busy(s_md_busy), .stall_count(s_stall_count)
    );

    // we = {pc,fd,dx,xm,mw}; ctl = {fd_flush,dx_bubble,xm_bubble,go,timeout,busy}
    typedef struct packed {
        logic [4:0]  we;
        logic [5:0]  ctl;
        logic [31:0] cnt;
        logic [31:0] cnt_s;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int go_seen  = 0;
    int to_seen  = 0;

    // Behavioural reference state
    bit m_wait = 1'b0;
    int m_wcyc = 0;
    int m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t model_out(input logic rst, input logic la, input logic br,
                                       input logic ms, input logic mr);
        exp_t e;
        e.we  = 5'b11111;
        e.ctl = 6'b000000;
        if (!rst) begin
            e.we  = 5'b00000;
            e.ctl = 6'b111000;
        end else if (m_wait) begin
            if (mr)                      e.ctl = 6'b000001;
            else if (m_wcyc == MD_TO - 1) e.ctl = 6'b000011;
            else begin
                e.we  = 5'b00011;
                e.ctl = 6'b001001;
            end
        end else if (ms) begin
            e.we  = 5'b00011;
            e.ctl = 6'b001100;
        end else if (br) begin
            e.ctl = 6'b110000;
        end else if (la) begin
            e.we  = 5'b00111;
            e.ctl = 6'b010000;
        end
        e.cnt   = (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt);
        e.cnt_s = (m_cnt > 15) ? 32'd15 : 32'(m_cnt);
        return e;
    endfunction

    task automatic model_advance(input logic rst, input logic ms, input logic mr,
                                 input logic pc_we_exp);
        if (!rst) begin
            m_wait = 1'b0;
            m_cnt  = 0;
        end else begin
            if (!pc_we_exp) m_cnt++;
            if (!m_wait) begin
                if (ms) begin
                    m_wait = 1'b1;
                    m_wcyc = 0;
                end
            end else if (mr || m_wcyc == MD_TO - 1) begin
                m_wait = 1'b0;
            end else begin
                m_wcyc++;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic la, input logic br,
                         input logic ms, input logic mr);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        la_stall     = la;
        branch_taken = br;
        md_start     = ms;
        md_ready     = mr;
        e = model_out(rst, la, br, ms, mr);
        exp_q.push_back(e);
        model_advance(rst, ms, mr, e.we[4]);

        @(negedge clock);
        e = exp_q.pop_front();
        check("we",      32'({pc_we, fd_we, dx_we, xm_we, mw_we}), 32'(e.we));
        check("ctl",     32'({fd_flush, dx_bubble, xm_bubble, md_go, md_timeout, md_busy}), 32'(e.ctl));
        check("cnt",     32'(stall_count), e.cnt);
        check("we_s",    32'({s_pc_we, s_fd_we, s_dx_we, s_xm_we, s_mw_we}), 32'(e.we));
        check("ctl_s",   32'({s_fd_flush, s_dx_bubble, s_xm_bubble, s_md_go, s_md_timeout, s_md_busy}), 32'(e.ctl));
        check("cnt_s",   32'(s_stall_count), e.cnt_s);
        if (md_go === 1'b1)      go_seen++;
        if (md_timeout === 1'b1) to_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; la_stall = 1'b0; branch_taken = 1'b0;
        md_start = 1'b0; md_ready = 1'b0;

        // 1: reset held with la_stall, then release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("t1_cnt", 32'(stall_count), 32'd0);

        // 2: single load-use stall; an md_ready in RUN is ignored
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_cnt", 32'(stall_count), 32'd1);

        // 3: multdiv with ready at T+17
        go_seen = 0;
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("t3_go", 32'(go_seen), 32'd1);
        check("t3_cnt", 32'(stall_count), 32'd18);

        // 4a: no ready, timeout at T+40
        to_seen = 0;
        for (int i = 0; i < 41; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("t4a_to", 32'(to_seen), 32'd1);
        check("t4a_cnt", 32'(stall_count), 32'd58);

        // 4b: ready coincides with timeout, ready wins
        to_seen = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("t4b_to", 32'(to_seen), 32'd0);
        check("t4b_cnt", 32'(stall_count), 32'd98);

        // 5: branch beats la_stall; md_start (with ready, dropped) beats branch
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_cnt", 32'(stall_count), 32'd98);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // 6: fresh reset, long wait saturates the 4-bit counter, reset mid-wait
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_seen = 0;
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_sat", 32'(s_stall_count), 32'd15);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t6_to", 32'(to_seen), 32'd0);
        check("t6_cnt", 32'(stall_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
